// File: rtl/result_uart_tx.sv
// result_uart_tx: FIFO-buffered 8N1 UART transmitter for the processor result stream
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pause,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       overflow_clr,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          push, pop, last;
  assign full  = count == (AW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign push  = data_valid & ~full;
  assign pop   = (state == IDLE) & ~empty & ~pause;
  assign last  = cnt == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk)
    if (push) mem[wptr] <= data_in;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wptr     <= wptr + AW'(push);
      rptr     <= rptr + AW'(pop);
      count    <= count + (AW+1)'(push) - (AW+1)'(pop);
      overflow <= (data_valid & full) | (overflow & ~overflow_clr);
    end
  end
  // pause freezes every FSM register in place, including the IDLE pop decision
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
    end else if (!pause) begin
      cnt <= (state == IDLE || last) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (pop) begin
          state <= START;
          shreg <= mem[rptr];
          tx    <= 1'b0;
          busy  <= 1'b1;
        end
        START: if (last) begin
          state <= DATA;
          idx   <= '0;
          tx    <= shreg[0];
        end
        DATA: if (last) begin
          shreg <= shreg >> 1;
          idx   <= idx + 1'b1;
          tx    <= (idx == 3'd7) | shreg[1];
          if (idx == 3'd7) state <= STOP;
        end
        STOP: if (last) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_result_uart_tx.sv
// tb_result_uart_tx: table-driven frames plus corner sequences, decoded by a line monitor against a byte scoreboard
module tb_result_uart_tx;
  localparam int C = 4;
  logic       clk = 0, rstn = 1, pause = 0, data_valid = 0, overflow_clr = 0;
  logic [7:0] data_in = 0;
  logic       tx, busy, full, empty, overflow;
  int         n_chk = 0, n_fail = 0;
  logic [7:0] sb [$];
  result_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .pause(pause), .data_in(data_in), .data_valid(data_valid),
    .overflow_clr(overflow_clr), .tx(tx), .busy(busy), .full(full), .empty(empty), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  logic       pause_q = 0, active = 0;
  logic [7:0] sh = 0;
  int         cyc = 0, k = 0, len = 0, gap = 0, last_start = 0, frames = 0, last_len = 0;
  always @(posedge clk) pause_q <= pause;
  // receiver: k counts unpaused cycles since the start edge, bits sampled mid-bit
  always @(negedge clk) begin
    cyc++;
    if (!rstn) active = 0;
    else if (!active) begin
      if (tx === 1'b0) begin
        active = 1; k = 0; len = 1; gap = cyc - last_start; last_start = cyc;
      end
    end else if (!busy) begin
      active = 0; last_len = len; frames++;
    end else begin
      len++;
      if (!pause_q) begin
        k++;
        if (k >= 6 && k <= 34 && (k - 6) % 4 == 0) sh = {tx, sh[7:1]};
        if (k == 38) begin
          check("stop_bit", tx, 1);
          if (sb.size() == 0) check("unexpected_frame", sb.size(), 1);
          else check("rx_byte", sh, sb.pop_front());
        end
      end
    end
  end
  task automatic wait_frames(input int n);
    int t = 0;
    while (frames < n && t < 3000) begin @(posedge clk); #1; t++; end
    check("frame_timeout", frames >= n, 1);
  endtask
  task automatic put(input logic [7:0] d, input bit acc);
    data_in = d; data_valid = 1;
    if (acc) sb.push_back(d);
    @(posedge clk); #1 data_valid = 0;
  endtask
  typedef struct { logic [7:0] d; int plen; int exp_len; } vec_t;
  vec_t v [5];
  initial begin
    int lat;
    v[0] = '{8'hA5, 0, 40};
    v[1] = '{8'h3C, 7, 47};
    v[2] = '{8'h00, 0, 40};
    v[3] = '{8'hFF, 3, 43};
    v[4] = '{8'h81, 1, 41};
    #1 rstn = 0;
    #2;
    check("rst_tx", tx, 1); check("rst_busy", busy, 0); check("rst_full", full, 0);
    check("rst_empty", empty, 1); check("rst_overflow", overflow, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    for (int i = 0; i < 5; i++) begin
      data_in = v[i].d; data_valid = 1; sb.push_back(v[i].d);
      @(posedge clk); #1 data_valid = 0; lat = 1;
      check("empty_fall", empty, 0);
      while (tx !== 1'b0 && lat < 10) begin @(posedge clk); #1; lat++; end
      check("start_latency", lat, 2);
      if (v[i].plen > 0) begin
        repeat (13) @(posedge clk);
        #1 pause = 1;
        repeat (v[i].plen) begin @(posedge clk); #1 check("pause_hold", tx, v[i].d[2]); end
        pause = 0;
      end
      wait_frames(i + 1);
      check("frame_len", last_len, v[i].exp_len);
      check("empty_after", empty, 1);
    end
    for (int i = 1; i <= 5; i++) begin
      data_in = 8'(i); data_valid = 1; sb.push_back(8'(i));
      @(posedge clk); #1;
    end
    check("burst_full", full, 1);
    data_in = 8'h06;
    @(posedge clk); #1 data_valid = 0;
    check("burst_overflow", overflow, 1);
    check("burst_full_held", full, 1);
    for (int j = 1; j <= 5; j++) begin
      wait_frames(5 + j);
      if (j > 1) check("burst_gap", gap, 41);
    end
    overflow_clr = 1;
    @(posedge clk); #1 overflow_clr = 0;
    check("ovf_clear", overflow, 0);
    pause = 1;
    put(8'hFF, 1);
    repeat (8) begin
      @(posedge clk); #1;
      check("paused_idle_tx", tx, 1); check("paused_idle_busy", busy, 0);
    end
    pause = 0;
    @(posedge clk); #1;
    check("release_start_tx", tx, 0); check("release_start_busy", busy, 1);
    wait_frames(11);
    pause = 1;
    put(8'h11, 1); put(8'h22, 1); put(8'h33, 1); put(8'h44, 1);
    check("fill_full", full, 1);
    overflow_clr = 1;
    put(8'h55, 0);
    overflow_clr = 0;
    check("set_beats_clear", overflow, 1);
    overflow_clr = 1;
    @(posedge clk); #1 overflow_clr = 0;
    check("ovf_clear2", overflow, 0);
    pause = 0;
    wait_frames(15);
    check("sb_drained", sb.size(), 0);
    put(8'h5A, 0);
    lat = 0;
    while (tx !== 1'b0 && lat < 10) begin @(posedge clk); #1; lat++; end
    check("rst_frame_started", tx, 0);
    put(8'h66, 0);
    repeat (20) @(posedge clk);
    #1 rstn = 0;
    #1;
    check("mid_rst_tx", tx, 1); check("mid_rst_busy", busy, 0);
    check("mid_rst_empty", empty, 1); check("mid_rst_overflow", overflow, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    repeat (60) begin
      @(posedge clk); #1;
      check("post_rst_tx", tx, 1); check("post_rst_busy", busy, 0);
    end
    check("post_rst_frames", frames, 15);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
